pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the write-enable and flush (bubble) controls of the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers from three sources, in priority order: data-memory wait, taken branch/jump in EX, and load-use hazard. It also runs a data-memory wait watchdog with a sticky error state, and keeps saturating stall and flush counters for performance monitoring.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum number of consecutive data-memory stall cycles before the block enters the error state (valid range 2..255).
- CNT_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- rs1_ID, rs2_ID  in  5  source register indices of the instruction in ID.
- rs1_used_ID, rs2_used_ID  in  1  the instruction in ID actually reads rs1 / rs2.
- rd_EX  in  5  destination register of the instruction in EX.
- MemRead_EX  in  1  the instruction in EX is a load.
- branch_taken_EX  in  1  redirect (taken branch, JAL or JALR) resolved in EX this cycle.
- dmem_req_MEM  in  1  data-memory access in progress in MEM.
- dmem_ready_MEM  in  1  data memory completes the access this cycle.
- pc_we, if_id_we, id_ex_we, ex_mem_we  out  1  register enables (1 = load).
- if_id_flush, id_ex_flush, mem_wb_flush  out  1  load a bubble: instruction NOP, RegWrite 0, WBSel WB_NONE.
- mem_err  out  1  sticky watchdog error.
- state  out  2  current FSM state (hz_state_e).
- stall_cnt, flush_cnt  out  CNT_WIDTH  saturating performance counters.

## Operation
- Derived signals: mem_stall = dmem_req_MEM & ~dmem_ready_MEM; load_use = MemRead_EX & (rd_EX != 0) & ((rs1_used_ID & rs1_ID == rd_EX) | (rs2_used_ID & rs2_ID == rd_EX)).
- All enable and flush outputs are combinational (Mealy) from the state and the current-cycle inputs. Default is all *_we = 1 and all *_flush = 0.
- FSM states are HZ_RUN, HZ_MEM_WAIT and HZ_ERROR. The wait counter wait_cnt is 8 bits.
- HZ_RUN and HZ_MEM_WAIT share one priority evaluation:
  - If mem_stall: pc/if_id/id_ex/ex_mem_we = 0 and mem_wb_flush = 1. The next state is HZ_MEM_WAIT.
  - Else if branch_taken_EX: if_id_flush = 1 and id_ex_flush = 1, with all enables 1. load_use is ignored, because the dependent instruction is squashed.
  - Else if load_use: pc_we = 0, if_id_we = 0 and id_ex_flush = 1; the other enables stay 1.
- In HZ_RUN, a mem_stall sets wait_cnt to 1.
- In HZ_MEM_WAIT:
  - While mem_stall holds, wait_cnt increments.
  - When the count of consecutive stalled cycles reaches MEM_TIMEOUT, the next state is HZ_ERROR.
  - When dmem_ready_MEM = 1, the cycle is evaluated with mem_stall = 0 (branch and load-use still apply) and the next state is HZ_RUN.
- In HZ_ERROR: all *_we = 0, mem_wb_flush = 1 and mem_err = 1. The block holds this state until rst, ignoring all other inputs.
- stall_cnt increments on every cycle with pc_we = 0 in HZ_RUN or HZ_MEM_WAIT. flush_cnt increments on every cycle with if_id_flush = 1. Both saturate at all-ones.

## Timing
- While rst = 1: all *_we = 0, all *_flush = 1, mem_err = 0, counters 0 and wait_cnt 0. The state is HZ_RUN on the first cycle after rst deasserts.
- Reset asserted mid-wait or in HZ_ERROR returns the block to HZ_RUN and clears mem_err and the counters.
- Zero-latency response: a hazard visible at cycle t produces its controls in the same cycle t, and they take effect at the edge ending t.
- Load-use costs exactly 1 bubble cycle. At t+1 the load is in MEM, load_use deasserts and forwarding covers the dependency.
- Watchdog: a stall first seen at cycle t with dmem_ready_MEM never asserting gives stalled cycles t .. t+MEM_TIMEOUT-1, and HZ_ERROR from t+MEM_TIMEOUT. Ready at t+MEM_TIMEOUT-1 completes normally with no error.
- Simultaneous events: mem_stall masks a branch or load-use arriving in the same cycle. The EX instruction is frozen, so the event re-presents when the wait ends.
- rd_EX = 0 never causes a load-use stall.

## Structure
- Add to the shared defines package: the hz_state_e enum (HZ_RUN = 0, HZ_MEM_WAIT = 1, HZ_ERROR = 2) and the default MEM_TIMEOUT constant.
- Sub-module: load_use_detect, a combinational comparator producing load_use. All other logic lives in the top module.

## Test plan
- Load-use: MemRead_EX = 1, rd_EX = 5, rs1_ID = 5, rs1_used_ID = 1 → that cycle pc_we = 0, if_id_we = 0, id_ex_flush = 1; stall_cnt = 1; next cycle all enables 1.
- rd_EX = 0 with a matching rs1_ID = 0 → no stall. The same match with rs2_used_ID = 0 on an rs2 match → no stall.
- Branch and load-use in the same cycle → if_id_flush = 1, id_ex_flush = 1, pc_we = 1; flush_cnt increments by 1, stall_cnt unchanged.
- dmem_req_MEM = 1 with ready low for 3 cycles, then high → 3 cycles of all *_we = 0 with mem_wb_flush = 1; state = 1 on cycles 2-3; the ready cycle has all enables 1; then HZ_RUN.
- MEM_TIMEOUT = 4 with ready never asserting → mem_err = 1 and state = 2 from the 5th cycle, sticky. Then rst for 1 cycle → all outputs at reset values, then HZ_RUN.
- Branch during an active mem wait → mem stall controls only. After ready, the held branch produces the flush outputs in the ready cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared defines for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1,
    HZ_ERROR    = 2'd2
  } hz_state_e;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard comparator between ID and EX
module load_use_detect (
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       rs1_used_ID,
  input  logic       rs2_used_ID,
  input  logic [4:0] rd_EX,
  input  logic       MemRead_EX,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used_ID && (rs1_ID == rd_EX);
  assign rs2_hit  = rs2_used_ID && (rs2_ID == rd_EX);
  // x0 is never really written, so a load targeting it creates no dependency
  assign load_use = MemRead_EX && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller with dmem watchdog and perf counters
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rs1_ID,
  input  logic [4:0]           rs2_ID,
  input  logic                 rs1_used_ID,
  input  logic                 rs2_used_ID,
  input  logic [4:0]           rd_EX,
  input  logic                 MemRead_EX,
  input  logic                 branch_taken_EX,
  input  logic                 dmem_req_MEM,
  input  logic                 dmem_ready_MEM,
  output logic                 pc_we,
  output logic                 if_id_we,
  output logic                 id_ex_we,
  output logic                 ex_mem_we,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_wb_flush,
  output logic                 mem_err,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam logic [7:0]           TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  hz_state_e  state_q;
  hz_state_e  state_d;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_d;
  logic [7:0] wait_inc;
  logic       mem_stall;
  logic       load_use;

  load_use_detect u_load_use_detect (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .rs1_used_ID (rs1_used_ID),
    .rs2_used_ID (rs2_used_ID),
    .rd_EX       (rd_EX),
    .MemRead_EX  (MemRead_EX),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req_MEM && !dmem_ready_MEM;
  assign wait_inc  = wait_cnt + 8'd1;

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt;

    if (rst) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = HZ_RUN;
      wait_cnt_d   = 8'd0;
    end else if (state_q == HZ_ERROR) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; branch and load-use re-present once memory answers
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_flush = 1'b1;
      if (state_q == HZ_RUN) begin
        wait_cnt_d = 8'd1;
        state_d    = HZ_MEM_WAIT;
      end else begin
        wait_cnt_d = wait_inc;
        state_d    = (wait_inc >= TIMEOUT) ? HZ_ERROR : HZ_MEM_WAIT;
      end
    end else begin
      state_d    = HZ_RUN;
      wait_cnt_d = 8'd0;
      if (branch_taken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HZ_RUN;
      wait_cnt  <= 8'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_cnt_d;
      if (!pc_we && (state_q != HZ_ERROR) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

  assign mem_err = !rst && (state_q == HZ_ERROR);
  assign state   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        rs1_used_ID, rs2_used_ID, MemRead_EX, branch_taken_EX;
  logic        dmem_req_MEM, dmem_ready_MEM;

  logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we;
  logic        b_if_id_flush, b_id_ex_flush, b_mem_wb_flush, b_mem_err;
  logic [1:0]  b_state;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready_MEM(dmem_ready_MEM),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready_MEM(dmem_ready_MEM),
    .pc_we(b_pc_we), .if_id_we(b_if_id_we), .id_ex_we(b_id_ex_we), .ex_mem_we(b_ex_mem_we),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .mem_wb_flush(b_mem_wb_flush),
    .mem_err(b_mem_err), .state(b_state), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, req, rdy;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      s;
    logic [6:0] exp;  // {pc, if_id, id_ex, ex_mem we, if_id, id_ex, mem_wb flush}
  } vec_t;

  int     chk_cnt = 0;
  int     err_cnt = 0;
  int     cons    = 0;     // consecutive stalled cycles seen so far
  bit     errored = 1'b0;
  longint scnt    = 0;
  longint fcnt    = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk(logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                               logic [4:0] rd, logic mr, logic br, logic req, logic rdy);
    stim_t s;
    s.rst = 1'b0; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.rd = rd; s.mr = mr; s.br = br; s.req = req; s.rdy = rdy;
    return s;
  endfunction

  function automatic logic [6:0] model_ctl(stim_t s);
    bit lu;
    if (s.rst) return 7'b0000_111;
    if (errored) return 7'b0000_001;
    lu = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    if (s.req && !s.rdy) return 7'b0000_001;
    if (s.br) return 7'b1111_110;
    if (lu) return 7'b0011_010;
    return 7'b1111_000;
  endfunction

  task automatic step(stim_t s, output logic [6:0] got);
    logic [6:0] exp;
    logic [1:0] exp_state;
    longint     sat_s, sat_f;
    rst = s.rst; rs1_ID = s.rs1; rs2_ID = s.rs2; rs1_used_ID = s.u1; rs2_used_ID = s.u2;
    rd_EX = s.rd; MemRead_EX = s.mr; branch_taken_EX = s.br;
    dmem_req_MEM = s.req; dmem_ready_MEM = s.rdy;
    #4;
    exp       = model_ctl(s);
    exp_state = errored ? 2'd2 : ((cons > 0) ? 2'd1 : 2'd0);
    sat_s     = (scnt > 15) ? 15 : scnt;
    sat_f     = (fcnt > 15) ? 15 : fcnt;
    got = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush};
    check("ctl", got, exp);
    check("mem_err", mem_err, !s.rst && errored);
    check("state", state, exp_state);
    check("stall_cnt", stall_cnt, scnt);
    check("flush_cnt", flush_cnt, fcnt);
    check("sat_ctl", {b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_if_id_flush,
                      b_id_ex_flush, b_mem_wb_flush, b_mem_err, b_state},
          {exp, !s.rst && errored, exp_state});
    check("sat_stall_cnt", b_stall_cnt, sat_s);
    check("sat_flush_cnt", b_flush_cnt, sat_f);
    @(posedge clk);
    if (s.rst) begin
      cons = 0; errored = 1'b0; scnt = 0; fcnt = 0;
    end else if (!errored) begin
      if (!exp[6]) scnt++;
      if (exp[2]) fcnt++;
      if (s.req && !s.rdy) begin
        cons++;
        if (cons >= MT) errored = 1'b1;
      end else begin
        cons = 0;
      end
    end
    #1;
  endtask

  vec_t       vecs[$];
  stim_t      st;
  logic [6:0] got;

  initial begin
    vecs.push_back('{"lu_rs1",      mk(5, 1, 0, 0, 5, 1, 0, 0, 0), 7'b0011_010});
    vecs.push_back('{"idle",        mk(5, 1, 0, 0, 5, 0, 0, 0, 0), 7'b1111_000});
    vecs.push_back('{"rd0_nostall", mk(0, 1, 0, 1, 0, 1, 0, 0, 0), 7'b1111_000});
    vecs.push_back('{"rs2_unused",  mk(1, 0, 7, 0, 7, 1, 0, 0, 0), 7'b1111_000});
    vecs.push_back('{"lu_rs2",      mk(1, 0, 7, 1, 7, 1, 0, 0, 0), 7'b0011_010});
    vecs.push_back('{"br_and_lu",   mk(9, 1, 0, 0, 9, 1, 1, 0, 0), 7'b1111_110});
    vecs.push_back('{"no_load",     mk(9, 1, 9, 1, 9, 0, 0, 0, 0), 7'b1111_000});
    vecs.push_back('{"req_ready",   mk(3, 1, 0, 0, 3, 1, 0, 1, 1), 7'b0011_010});
    vecs.push_back('{"br_only",     mk(0, 0, 0, 0, 0, 0, 1, 0, 0), 7'b1111_110});

    rst = 1'b1; rs1_ID = '0; rs2_ID = '0; rd_EX = '0; rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
    MemRead_EX = 1'b0; branch_taken_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ready_MEM = 1'b0;
    @(posedge clk); #1;
    st = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); st.rst = 1'b1;
    step(st, got);

    foreach (vecs[i]) begin
      step(vecs[i].s, got);
      check(vecs[i].name, got, vecs[i].exp);
    end

    // three stalled cycles then ready
    for (int i = 0; i < 3; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), got);
      check("wait_ctl", got, 7'b0000_001);
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    check("wait_release", got, 7'b1111_000);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), got);
    check("after_wait_state", state, 2'd0);

    // branch held behind a memory wait
    for (int i = 0; i < 2; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 1, 1, 0), got);
      check("br_masked", got, 7'b0000_001);
    end
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1), got);
    check("br_after_ready", got, 7'b1111_110);

    // ready in the last allowed stalled cycle completes normally
    for (int i = 0; i < MT - 1; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), got);
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), got);
    check("edge_no_err", mem_err, 1'b0);

    // watchdog timeout, sticky error, then reset
    for (int i = 0; i < MT; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), got);
    check("err_entered", {mem_err, state}, {1'b1, 2'd2});
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, 1), got);
    check("err_sticky", got, 7'b0000_001);
    st = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); st.rst = 1'b1;
    step(st, got);
    check("rst_ctl", got, 7'b0000_111);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), got);
    check("post_rst", {mem_err, state, stall_cnt}, {1'b0, 2'd0, 32'd0});

    for (int i = 0; i < 1200; i++) begin
      st.rst = ($urandom_range(0, 59) == 0);
      st.rs1 = 5'($urandom_range(0, 3));
      st.rs2 = 5'($urandom_range(0, 3));
      st.rd  = 5'($urandom_range(0, 3));
      st.u1  = 1'($urandom);
      st.u2  = 1'($urandom);
      st.mr  = 1'($urandom);
      st.br  = ($urandom_range(0, 3) == 0);
      st.req = 1'($urandom);
      st.rdy = ((i / 64) % 2 == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom);
      step(st, got);
    end

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
